// File: rtl/gpio_port_bank_pkg.sv
// Shared defaults and helpers for the GPIO port bank: parameter defaults,
// select-width calculation and the flat pin-bus slice offset.
package gpio_port_bank_pkg;

    localparam int DEF_NUM_PORTS   = 3;
    localparam int DEF_PORT_WIDTH  = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Port p occupies bits [port_lo(p,w) +: w] of pinIn / pinOut / pinOe.
    function automatic int port_lo(input int p, input int w);
        return p * w;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_port_slice.sv
// One GPIO port: output latch, TRIS, IOC mask, input synchroniser,
// change snapshot and the sticky interrupt-on-change flag.
module gpio_port_slice
    import gpio_port_bank_pkg::*;
#(
    parameter int PORT_WIDTH  = DEF_PORT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sel,
    input  logic [PORT_WIDTH-1:0] i_wr_data,
    input  logic                  i_data_we,
    input  logic                  i_tris_we,
    input  logic                  i_mask_we,
    input  logic                  i_ioc_clr,
    input  logic [PORT_WIDTH-1:0] i_pin,
    output logic [PORT_WIDTH-1:0] o_pin_out,
    output logic [PORT_WIDTH-1:0] o_pin_oe,
    output logic [PORT_WIDTH-1:0] o_sync,
    output logic                  o_ioc_flag
);

    logic [PORT_WIDTH-1:0]                  r_data;
    logic [PORT_WIDTH-1:0]                  r_tris;
    logic [PORT_WIDTH-1:0]                  r_mask;
    logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] r_sync;
    logic [PORT_WIDTH-1:0]                  r_snap;
    logic                                   r_flag;
    logic [PORT_WIDTH-1:0]                  w_sync;
    logic [PORT_WIDTH-1:0]                  w_change;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    // Output-mode bits (TRIS = 0) are masked off so driven pads never flag.
    assign w_change = (w_sync ^ r_snap) & r_mask & r_tris;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_tris <= '1;
            r_mask <= '0;
            r_snap <= '0;
            r_flag <= 1'b0;
            r_sync <= '0;
        end else begin
            if (i_sel && i_data_we) r_data <= i_wr_data;
            if (i_sel && i_tris_we) r_tris <= i_wr_data;
            if (i_sel && i_mask_we) r_mask <= i_wr_data;

            r_sync[0] <= i_pin;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_snap <= w_sync;

            // A new change beats a coincident clear.
            if (|w_change) begin
                r_flag <= 1'b1;
            end else if (i_sel && i_ioc_clr) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign o_pin_out  = r_data;
    assign o_pin_oe   = ~r_tris;
    assign o_sync     = w_sync;
    assign o_ioc_flag = r_flag;

endmodule

// File: rtl/gpio_port_bank.sv
// GPIO port bank top: decodes portSel, muxes the synchronised read data and
// ORs the per-port change flags; all state lives in gpio_port_slice.
module gpio_port_bank
    import gpio_port_bank_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int PORT_WIDTH  = DEF_PORT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int SEL_W      = sel_width(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SEL_W-1:0]                portSel,
    input  logic [PORT_WIDTH-1:0]           wrData,
    input  logic                            dataWe,
    input  logic                            trisWe,
    input  logic                            iocMaskWe,
    input  logic                            iocClr,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] pinIn,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pinOut,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pinOe,
    output logic [PORT_WIDTH-1:0]           rdData,
    output logic [NUM_PORTS-1:0]            iocFlag,
    output logic                            iocAny
);

    logic [NUM_PORTS-1:0]                 w_sel;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] w_sync;

    // An out-of-range portSel matches no slice, so it writes nothing and reads 0.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_sel[p] = (int'(portSel) == p);

        gpio_port_slice #(
            .PORT_WIDTH (PORT_WIDTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .i_sel     (w_sel[p]),
            .i_wr_data (wrData),
            .i_data_we (dataWe),
            .i_tris_we (trisWe),
            .i_mask_we (iocMaskWe),
            .i_ioc_clr (iocClr),
            .i_pin     (pinIn [port_lo(p, PORT_WIDTH) +: PORT_WIDTH]),
            .o_pin_out (pinOut[port_lo(p, PORT_WIDTH) +: PORT_WIDTH]),
            .o_pin_oe  (pinOe [port_lo(p, PORT_WIDTH) +: PORT_WIDTH]),
            .o_sync    (w_sync[p]),
            .o_ioc_flag(iocFlag[p])
        );
    end

    // NOTE: the default assignment first keeps this combinational mux latch-free.
    always_comb begin
        rdData = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_sel[p]) rdData = w_sync[p];
        end
    end

    assign iocAny = |iocFlag;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed self-checking bench for gpio_port_bank at default parameters
// (3 ports x 8 bits, 2-stage synchroniser).
module tb_gpio_port_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  portSel;
    logic [7:0]  wrData;
    logic        dataWe, trisWe, iocMaskWe, iocClr;
    logic [23:0] pinIn;
    logic [23:0] pinOut, pinOe;
    logic [7:0]  rdData;
    logic [2:0]  iocFlag;
    logic        iocAny;

    int checks = 0;
    int errors = 0;

    gpio_port_bank dut (
        .clk      (clk),
        .rst      (rst),
        .portSel  (portSel),
        .wrData   (wrData),
        .dataWe   (dataWe),
        .trisWe   (trisWe),
        .iocMaskWe(iocMaskWe),
        .iocClr   (iocClr),
        .pinIn    (pinIn),
        .pinOut   (pinOut),
        .pinOe    (pinOe),
        .rdData   (rdData),
        .iocFlag  (iocFlag),
        .iocAny   (iocAny)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".pinOe"},   32'(pinOe),   32'h0);
        check({tag, ".pinOut"},  32'(pinOut),  32'h0);
        check({tag, ".iocFlag"}, 32'(iocFlag), 32'h0);
        check({tag, ".iocAny"},  32'(iocAny),  32'h0);
        check({tag, ".rdData"},  32'(rdData),  32'h0);
    endtask

    initial begin
        rst = 1'b1; portSel = 2'd0; wrData = 8'h00;
        dataWe = 1'b0; trisWe = 1'b0; iocMaskWe = 1'b0; iocClr = 1'b0;
        pinIn = 24'h0;
        tick(2);
        check_idle("in_reset");
        rst = 1'b0;
        tick(2);
        check_idle("after_reset");

        // TRIS then data write on port 1, each visible one cycle after the write.
        portSel = 2'd1; wrData = 8'h0F; trisWe = 1'b1;
        tick();
        check("tris_p1", 32'(pinOe), 32'h00F000);
        trisWe = 1'b0; wrData = 8'hA5; dataWe = 1'b1;
        check("data_p1_before", 32'(pinOut), 32'h0);
        tick();
        check("data_p1", 32'(pinOut), 32'h00A500);
        dataWe = 1'b0;

        // Writes to a nonexistent port are dropped.
        portSel = 2'd3; wrData = 8'hFF; dataWe = 1'b1; trisWe = 1'b1; iocMaskWe = 1'b1;
        tick();
        dataWe = 1'b0; trisWe = 1'b0; iocMaskWe = 1'b0;
        check("oor_pinOut", 32'(pinOut), 32'h00A500);
        check("oor_pinOe",  32'(pinOe),  32'h00F000);

        // Synchroniser latency: visible exactly two cycles after the pin changes.
        portSel = 2'd0; pinIn = 24'h00003C;
        tick();
        check("sync_t1", 32'(rdData), 32'h0);
        tick();
        check("sync_t2", 32'(rdData), 32'h3C);
        portSel = 2'd3;
        #1 check("rd_oor", 32'(rdData), 32'h0);

        // Port 2 IOC: mask bit0, toggle bit0 -> flag at t+3.
        portSel = 2'd2; wrData = 8'h01; iocMaskWe = 1'b1;
        tick();
        iocMaskWe = 1'b0;
        pinIn = 24'h01003C;
        tick(2);
        check("ioc_t2", 32'(iocFlag), 32'h0);
        tick();
        check("ioc_t3", 32'(iocFlag), 32'h4);
        check("ioc_any", 32'(iocAny), 32'h1);
        check("rd_p2", 32'(rdData), 32'h01);

        iocClr = 1'b1;
        tick();
        iocClr = 1'b0;
        check("ioc_clr", 32'(iocFlag), 32'h0);
        check("ioc_any_clr", 32'(iocAny), 32'h0);
        pinIn = 24'h03003C;
        tick(4);
        check("ioc_unmasked_bit1", 32'(iocFlag), 32'h0);

        // Clear coinciding with the setting edge: set wins.
        pinIn = 24'h02003C;
        tick(2);
        iocClr = 1'b1;
        tick();
        iocClr = 1'b0;
        check("set_wins", 32'(iocFlag), 32'h4);
        tick();
        check("set_holds", 32'(iocFlag), 32'h4);
        portSel = 2'd3; iocClr = 1'b1;
        tick();
        check("clr_oor_ignored", 32'(iocFlag), 32'h4);
        portSel = 2'd2;
        tick();
        iocClr = 1'b0;
        check("clr_later", 32'(iocFlag), 32'h0);

        // Mask write leaves an existing flag alone; zero mask suppresses new ones.
        pinIn = 24'h03003C;
        tick(3);
        check("ioc_again", 32'(iocFlag), 32'h4);
        wrData = 8'h00; iocMaskWe = 1'b1;
        tick();
        iocMaskWe = 1'b0;
        check("mask_keeps_flag", 32'(iocFlag), 32'h4);
        iocClr = 1'b1;
        tick();
        iocClr = 1'b0;
        pinIn = 24'h02003C;
        tick(4);
        check("mask_zero_no_flag", 32'(iocFlag), 32'h0);

        // Port 1: bits 7:4 are outputs and never flag, bits 3:0 inputs do.
        portSel = 2'd1; wrData = 8'hFF; iocMaskWe = 1'b1;
        tick();
        iocMaskWe = 1'b0;
        pinIn = 24'h02803C;
        tick(4);
        check("output_bit_no_flag", 32'(iocFlag), 32'h0);
        pinIn = 24'h02813C;
        tick(3);
        check("input_bit_flag", 32'(iocFlag), 32'h2);
        check("input_bit_any", 32'(iocAny), 32'h1);

        // All three write enables at once on port 0.
        portSel = 2'd0; wrData = 8'h81; dataWe = 1'b1; trisWe = 1'b1; iocMaskWe = 1'b1;
        tick();
        dataWe = 1'b0; trisWe = 1'b0; iocMaskWe = 1'b0;
        check("combo_pinOut", 32'(pinOut), 32'h00A581);
        check("combo_pinOe",  32'(pinOe),  32'h00F07E);
        check("combo_rd",     32'(rdData), 32'h3C);
        check("combo_flag",   32'(iocFlag), 32'h2);

        // Asynchronous reset mid-cycle with a flag set and pins driven.
        #3 rst = 1'b1;
        #1 check_idle("async_rst");
        tick(2);
        rst = 1'b0;
        tick(5);
        check("post_rst_no_flag", 32'(iocFlag), 32'h0);
        check("post_rst_pinOe",   32'(pinOe),   32'h0);
        check("post_rst_rd",      32'(rdData),  32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_port_bank.md
GPIO_PORT_BANK -- requirements
Module: gpio_port_bank

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, meaning number of independent I/O ports (1..8).
REQ-002 SHALL have parameter PORT_WIDTH, default 8, meaning bits per port (1..8).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth (2..4).
REQ-004 SHALL have local SEL_W = max(1, clog2(NUM_PORTS)).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port portSel, input, SEL_W, meaning the target port for every write, clear and read.
REQ-008 SHALL have port wrData, input, PORT_WIDTH, meaning the write data.
REQ-009 SHALL have port dataWe, input, 1, meaning write wrData to the output latch of portSel.
REQ-010 SHALL have port trisWe, input, 1, meaning write wrData to the TRIS register of portSel (1 = input).
REQ-011 SHALL have port iocMaskWe, input, 1, meaning write wrData to the interrupt-on-change mask of portSel.
REQ-012 SHALL have port iocClr, input, 1, meaning clear iocFlag[portSel].
REQ-013 SHALL have port pinIn, input, NUM_PORTS*PORT_WIDTH, meaning raw pad input (port p at bits p*PORT_WIDTH+:PORT_WIDTH).
REQ-014 SHALL have port pinOut, output, NUM_PORTS*PORT_WIDTH, meaning the output latch contents.
REQ-015 SHALL have port pinOe, output, NUM_PORTS*PORT_WIDTH, meaning pad drive enable, equal to the bitwise inverse of TRIS.
REQ-016 SHALL have port rdData, output, PORT_WIDTH, meaning the synchronised pin value of portSel (combinational mux).
REQ-017 SHALL have port iocFlag, output, NUM_PORTS, meaning per-port change-detected flag.
REQ-018 SHALL have port iocAny, output, 1, meaning the OR of iocFlag.

Function
REQ-019 A dataWe, trisWe or iocMaskWe write SHALL update its register on the next edge; pinOut/pinOe SHALL reflect it 1 cycle after the write.
REQ-020 dataWe, trisWe and iocMaskWe SHALL be independent; any combination in one cycle SHALL write all asserted targets with the same wrData.
REQ-021 If portSel >= NUM_PORTS, writes and iocClr SHALL be ignored and rdData SHALL be 0.
REQ-022 Every pin bit SHALL pass through SYNC_STAGES flops; rdData SHALL reflect a pinIn change exactly SYNC_STAGES cycles later.
REQ-023 A per-bit snapshot register SHALL load the synchroniser output every cycle.
REQ-024 The change vector for port p SHALL be (sync XOR snapshot) AND mask AND TRIS; output-mode bits never flag.
REQ-025 iocFlag[p] SHALL set on the edge after port p's change vector is non-zero, i.e. SYNC_STAGES+1 cycles after the pin edge.
REQ-026 iocFlag[p] SHALL remain set until iocClr with portSel = p.
REQ-027 If set and clear coincide on the same port, set SHALL win.
REQ-028 A mask write SHALL take effect for changes detected from the following cycle; a mask write SHALL NOT clear existing flags.
REQ-029 Pin changes shorter than one clock MAY be missed; no glitch capture is required.

Reset
REQ-030 On rst: TRIS SHALL be all ones, pinOe all zero, output latch zero, mask zero, synchroniser and snapshot zero, and iocFlag and iocAny zero.
REQ-031 Reset asserted mid-operation SHALL clear all state immediately, independent of clk.
REQ-032 Because the mask resets to zero, no spurious flag SHALL occur after reset release.

Structure
REQ-033 Parameter defaults and the pinIn/pinOut slice helper SHALL live in the shared define/package file alongside the existing IO widths.
REQ-034 One sub-module, gpio_port_slice, SHALL hold one port's registers, synchroniser and IOC logic, instantiated NUM_PORTS times by generate.
REQ-035 The top SHALL contain only select decode, the rdData mux and the iocAny reduction.

Verification
REQ-036 Apply reset, then release -> pinOe = 0 on all bits, pinOut = 0, iocFlag = 0, rdData = 0.
REQ-037 Write portSel=1, trisWe with 0x0F, then dataWe with 0xA5 -> pinOe slice1 = 0xF0 and pinOut slice1 = 0xA5, each 1 cycle after its write.
REQ-038 Drive pinIn port0 = 0x3C at cycle t -> rdData (portSel=0) = 0x3C at t+2 and not before (SYNC_STAGES=2).
REQ-039 Mask port2 = 0x01 with TRIS = 0xFF, toggle bit0 -> iocFlag[2] = 1 at t+3 and iocAny = 1; toggle bit1 -> no flag.
REQ-040 Hold the bit0 toggle pending and assert iocClr on port2 in the cycle the flag sets -> flag stays 1; a later iocClr -> 0.
REQ-041 Assert rst mid-sequence with flags set and pins driven -> all outputs return to REQ-030 values within the same cycle.
